// File: rtl/seg_display_scan.sv
// Time-multiplexed 8-digit hex display driver fed from the CPU LED strobe and performance counters.
// Shows frame-stable snapshots, optional leading-zero blanking and an LED-write indicator on digit 0's dp.
module seg_display_scan #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned UPD_HOLD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_cpu_enable,
   input  logic [31:0] led_data_in,
   input  logic [31:0] total_cycles,
   input  logic [31:0] condi_branch_num,
   input  logic [31:0] uncondi_branch_num,
   input  logic [31:0] bubble_num,
   input  logic [2:0]  disp_sel,
   input  logic        blank_lz,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        upd_flag
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned UPD_W = (UPD_HOLD > 0) ? $clog2(UPD_HOLD + 1) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      latch_q, latch_d;
   logic [31:0]      snap_q, snap_d;
   logic [UPD_W-1:0] upd_q, upd_d;
   logic             first_q, first_d;
   logic [7:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             flag_q, flag_d;

   logic        tick;
   logic        frame;
   logic        upd_on;
   logic        blank;
   logic [31:0] src;
   logic [3:0]  nib;
   logic [4:0]  sh;

   // Active-high gfedcba pattern for one hex nibble
   function automatic logic [6:0] hex_pat(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = 7'h77;
         4'hB: p = 7'h7C;
         4'hC: p = 7'h39;
         4'hD: p = 7'h5E;
         4'hE: p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

   always_comb begin
      tick   = (div_q == DIV_W'(SCAN_DIV - 1));
      frame  = tick && (idx_q == 3'd7);
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      idx_d  = tick ? idx_q + 3'd1 : idx_q;

      latch_d = led_cpu_enable ? led_data_in : latch_q;

      case (disp_sel)
         3'd0:    src = latch_q;
         3'd1:    src = total_cycles;
         3'd2:    src = condi_branch_num;
         3'd3:    src = uncondi_branch_num;
         3'd4:    src = bubble_num;
         default: src = 32'd0;
      endcase
      // Old latch value is used even if a write lands on the boundary
      snap_d  = (first_q || frame) ? src : snap_q;
      first_d = 1'b0;

      upd_on = (upd_q != '0);
      if (led_cpu_enable) begin
         upd_d = UPD_W'(UPD_HOLD);
      end else if (frame && upd_on) begin
         upd_d = upd_q - UPD_W'(1);
      end else begin
         upd_d = upd_q;
      end

      sh    = {idx_q, 2'b00};
      nib   = snap_q[sh +: 4];
      blank = blank_lz && (idx_q != 3'd0) && ((snap_q >> sh) == 32'd0);

      an_d       = ~(8'd1 << idx_q);
      seg_d[6:0] = blank ? 7'h7F : ~hex_pat(nib);
      seg_d[7]   = (idx_q == 3'd0) ? ~upd_on : 1'b1;
      flag_d     = upd_on;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         idx_q   <= '0;
         latch_q <= '0;
         snap_q  <= '0;
         upd_q   <= '0;
         first_q <= 1'b1;
         an_q    <= 8'hFF;
         seg_q   <= 8'hFF;
         flag_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         latch_q <= latch_d;
         snap_q  <= snap_d;
         upd_q   <= upd_d;
         first_q <= first_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         flag_q  <= flag_d;
      end
   end

   assign an       = an_q;
   assign seg      = seg_q;
   assign upd_flag = flag_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle model pushes expected pins, a negedge checker pops them.
module tb_seg_display_scan;

   localparam int SD   = 4;
   localparam int HOLD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        led_cpu_enable = 1'b0;
   logic [31:0] led_data_in = '0;
   logic [31:0] total_cycles = '0;
   logic [31:0] condi_branch_num = 32'h0000_0C0D;
   logic [31:0] uncondi_branch_num = 32'h0000_00E7;
   logic [31:0] bubble_num = 32'h0BAD_0042;
   logic [2:0]  disp_sel = 3'd0;
   logic        blank_lz = 1'b0;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        upd_flag;

   seg_display_scan #(.SCAN_DIV(SD), .UPD_HOLD(HOLD)) dut (
      .clk               (clk),
      .rst               (rst),
      .led_cpu_enable    (led_cpu_enable),
      .led_data_in       (led_data_in),
      .total_cycles      (total_cycles),
      .condi_branch_num  (condi_branch_num),
      .uncondi_branch_num(uncondi_branch_num),
      .bubble_num        (bubble_num),
      .disp_sel          (disp_sel),
      .blank_lz          (blank_lz),
      .an                (an),
      .seg               (seg),
      .upd_flag          (upd_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       flag;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference digit patterns in gfedcba order
   function automatic logic [6:0] pat(input int n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   // Model state
   int          m_div, m_idx, m_upd;
   logic [31:0] m_latch, m_snap;
   bit          m_first;

   task automatic m_reset();
      m_div = 0; m_idx = 0; m_upd = 0;
      m_latch = '0; m_snap = '0; m_first = 1'b1;
   endtask

   function automatic logic [31:0] pick(input logic [2:0] s, input logic [31:0] lat);
      if (s == 3'd0) return lat;
      if (s == 3'd1) return total_cycles;
      if (s == 3'd2) return condi_branch_num;
      if (s == 3'd3) return uncondi_branch_num;
      if (s == 3'd4) return bubble_num;
      return 32'd0;
   endfunction

   always @(negedge rst) begin
      m_reset();
      q.delete();
   end

   exp_t        e_m;
   logic [31:0] hi_m;
   bit          bnd_m;
   always @(posedge clk) begin
      if (!rst) begin
         m_reset();
         q.push_back('{an: 8'hFF, seg: 8'hFF, flag: 1'b0});
      end else begin
         hi_m     = m_snap >> (4 * m_idx);
         e_m.an   = ~(8'd1 << m_idx);
         e_m.flag = (m_upd > 0);
         if (blank_lz && m_idx > 0 && hi_m == 0)
            e_m.seg = 8'hFF;
         else
            e_m.seg = {(m_idx == 0) ? (m_upd == 0) : 1'b1, ~pat(int'(hi_m[3:0]))};
         q.push_back(e_m);

         bnd_m = (m_div == SD - 1) && (m_idx == 7);
         if (m_first || bnd_m) m_snap = pick(disp_sel, m_latch);
         m_first = 1'b0;
         if (led_cpu_enable) begin
            m_latch = led_data_in;
            m_upd   = HOLD;
         end else if (bnd_m && m_upd > 0) begin
            m_upd = m_upd - 1;
         end
         if (m_div == SD - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % 8;
         end else begin
            m_div = m_div + 1;
         end
      end
   end

   exp_t e_c;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e_c = q.pop_front();
         chk("an", 32'(an), 32'(e_c.an));
         chk("seg", 32'(seg), 32'(e_c.seg));
         chk("upd_flag", 32'(upd_flag), 32'(e_c.flag));
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total_cycles = total_cycles + 32'd3;
      end
   endtask

   // Advance until the model reaches the requested index/divider state
   task automatic wait_state(input int idx, input int dv);
      int b;
      b = 0;
      while (!(m_idx == idx && m_div == dv) && b < 400) begin
         step(1);
         b++;
      end
      if (b >= 400) chk("wait_timeout", 32'd1, 32'd0);
   endtask

   task automatic led_write(input logic [31:0] v);
      led_data_in    = v;
      led_cpu_enable = 1'b1;
      step(1);
      led_cpu_enable = 1'b0;
   endtask

   initial begin
      step(4);
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_seg", 32'(seg), 32'hFF);
      rst = 1'b1;
      step(1);
      chk("first_an", 32'(an), 32'hFE);
      chk("first_seg", 32'(seg), 32'hC0);
      step(40);

      led_write(32'h1234_ABCD);
      step(3 * 8 * SD);

      disp_sel = 3'd1;
      step(8 * SD);
      wait_state(3, 0);
      disp_sel = 3'd4;
      step(2 * 8 * SD);

      disp_sel = 3'd0;
      blank_lz = 1'b1;
      led_write(32'h0000_00A0);
      step(2 * 8 * SD);
      led_write(32'h0000_0000);
      step(2 * 8 * SD);
      blank_lz = 1'b0;

      step(3 * 8 * SD);
      wait_state(7, SD - 1);
      led_data_in    = 32'h0F1E_2D3C;
      led_cpu_enable = 1'b1;
      step(1);
      led_cpu_enable = 1'b0;
      chk("coll_upd", 32'(m_upd), 32'(HOLD));
      step(3 * 8 * SD);

      wait_state(5, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async_an", 32'(an), 32'hFF);
      chk("async_seg", 32'(seg), 32'hFF);
      chk("async_flag", 32'(upd_flag), 32'h0);
      step(3);
      rst = 1'b1;
      step(2 * 8 * SD);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
